// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states and
// datapath mux-select values.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_SEXT   = 2'b10;
  localparam logic [1:0] SRCB_SEXTSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> datapath control decoder (Moore outputs, ungated).
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  logic [3:0] i_state,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src,
  output logic       o_retire
);

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRCB_B;
    o_alu_op        = ALUOP_ADD;
    o_pc_src        = PCSRC_ALU;
    o_retire        = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_ir_write  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_pc_write  = 1'b1;
      end
      S_DECODE: o_alu_src_b = SRCB_SEXTSH;
      S_MEMADR, S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        o_retire     = 1'b1;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
        o_retire    = 1'b1;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_reg_dst   = 1'b1;
        o_reg_write = 1'b1;
        o_retire    = 1'b1;
      end
      // Branch resolves and retires here whether or not it is taken.
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALUOP_SUB;
        o_pc_write_cond = 1'b1;
        o_pc_src        = PCSRC_ALUOUT;
        o_retire        = 1'b1;
      end
      S_ADDIWB: begin
        o_reg_write = 1'b1;
        o_retire    = 1'b1;
      end
      S_JUMP: begin
        o_pc_write = 1'b1;
        o_pc_src   = PCSRC_JUMP;
        o_retire   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with retire counter and sticky illegal-opcode flag.
// Optional macro MIPS_MEM_WAIT_EN adds mem_ready stalls in FETCH/MEMRD/MEMWR.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
`ifdef MIPS_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [STATE_W-1:0] state,
  output logic               instr_retired,
  output logic [CNT_W-1:0]   instr_count,
  output logic               illegal_op
);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_illegal;
  logic             w_illegal_dec;
  logic             w_ready;
  logic             w_unused_zero;
  logic             w_dec_pc_write, w_dec_pc_write_cond, w_dec_mem_read, w_dec_mem_write;
  logic             w_dec_ir_write, w_dec_reg_write, w_dec_retire;
  logic             w_pc_write, w_ir_write, w_retire;

  // zero only qualifies pc_write_cond, which the datapath combines itself.
  assign w_unused_zero = zero;

`ifdef MIPS_MEM_WAIT_EN
  assign w_ready = mem_ready;
`else
  assign w_ready = 1'b1;
`endif

  mips_ctrl_outdec u_outdec (
    .i_state         (r_state),
    .o_pc_write      (w_dec_pc_write),
    .o_pc_write_cond (w_dec_pc_write_cond),
    .o_iord          (iord),
    .o_mem_read      (w_dec_mem_read),
    .o_mem_write     (w_dec_mem_write),
    .o_ir_write      (w_dec_ir_write),
    .o_reg_dst       (reg_dst),
    .o_mem_to_reg    (mem_to_reg),
    .o_reg_write     (w_dec_reg_write),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_pc_src        (pc_src),
    .o_retire        (w_dec_retire)
  );

  // A stalled fetch must not advance PC/IR; a stalled store has not retired yet.
  assign w_pc_write = w_dec_pc_write & ((r_state != S_FETCH) | w_ready);
  assign w_ir_write = w_dec_ir_write & w_ready;
  assign w_retire   = w_dec_retire & ((r_state != S_MEMWR) | w_ready);

  always_comb begin
    w_next        = S_FETCH;
    w_illegal_dec = 1'b0;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next        = S_FETCH;
            w_illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire)      r_count   <= r_count + CNT_W'(1);
      if (w_illegal_dec) r_illegal <= 1'b1;
    end
  end

  assign pc_write      = reset & w_pc_write;
  assign pc_write_cond = reset & w_dec_pc_write_cond;
  assign mem_read      = reset & w_dec_mem_read;
  assign mem_write     = reset & w_dec_mem_write;
  assign ir_write      = reset & w_ir_write;
  assign reg_write     = reset & w_dec_reg_write;
  assign instr_retired = reset & w_retire;
  assign state         = STATE_W'(r_state);
  assign instr_count   = r_count;
  assign illegal_op    = r_illegal;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut registers, one ALU.
- Replaces the single-cycle combinational opcode decoder for the multicycle variant of the core.
- Consumes opcode and ALU zero; drives every datapath mux select and write enable.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- opcode  in  6  instr[31:26] from IR
- zero  in  1  ALU zero flag
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extend, 11 = sign-extend << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct
- pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- state  out  STATE_W  current state, for debug
- instr_retired  out  1  one-cycle pulse in the final state of each instruction
- instr_count  out  CNT_W  retired-instruction count
- illegal_op  out  1  sticky illegal-opcode flag

Behaviour:
- Reset: reset is synchronous, active-low.
  - When reset==0 at a clk edge: state <= FETCH, instr_count <= 0, illegal_op <= 0.
  - While reset==0, all write enables and strobes are forced 0: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_retired.
  - Reset mid-instruction abandons that instruction; nothing is written.
- Outputs are a pure function of state (Moore), except the reset gating above.
- Signals not listed for a state are 0.
- States and outputs:
  - FETCH (0): mem_read, ir_write, alu_src_b=01, pc_write. Next: DECODE.
  - DECODE (1): alu_src_b=11 (branch target into ALUOut). Next by opcode:
    - 100011 (lw) or 101011 (sw): MEMADR
    - 000000 (R-type): EXEC
    - 000100 (beq): BRANCH
    - 001000 (addi): ADDIEX
    - 000010 (j): JUMP
    - any other: FETCH, and set illegal_op (not counted as retired).
  - MEMADR (2): alu_src_a=1, alu_src_b=10. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD (3): mem_read, iord. Next: MEMWB.
  - MEMWB (4): reg_write, mem_to_reg. Retire. Next: FETCH.
  - MEMWR (5): mem_write, iord. Retire. Next: FETCH.
  - EXEC (6): alu_src_a=1, alu_op=10. Next: ALUWB.
  - ALUWB (7): reg_dst, reg_write. Retire. Next: FETCH.
  - BRANCH (8): alu_src_a=1, alu_op=01, pc_write_cond, pc_src=01. Retire (taken or not). Next: FETCH.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10. Next: ADDIWB.
  - ADDIWB (10): reg_write. Retire. Next: FETCH.
  - JUMP (11): pc_write, pc_src=10. Retire. Next: FETCH.
- Unused encodings 12–15 go to FETCH on the next edge, with all outputs 0.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Retire: instr_retired is high exactly during the retiring state. instr_count increments on the edge leaving that state and wraps from 2^CNT_W-1 to 0.
- illegal_op stays set until reset.

Optional Feature:
- Macro: MIPS_MEM_WAIT_EN.
- When defined: adds input mem_ready (1 bit).
  - FETCH, MEMRD and MEMWR hold their state and outputs while mem_ready==0.
  - In FETCH, pc_write and ir_write are asserted only in the cycle mem_ready==1.
  - instr_retired for MEMWR pulses only in the cycle mem_ready==1.
- When undefined: no port; memory is treated as always ready, and the behaviour above is exact.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the state enum/localparams;
  - ALUOp, ALUSrcB and PCSrc encodings.
- Sub-module mips_ctrl_outdec: combinational state -> control-output decoder. The FSM, retire counter and illegal flag stay in the top.

Test Plan:
- Reset held 0 for 3 cycles, then released → state=0; instr_count=0; all write enables 0 during reset; first cycle after release shows mem_read=1, ir_write=1, pc_write=1.
- opcode=100011 → states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4; instr_count=1.
- Sequence sw, R-type, beq (zero=1), j → state paths 0,1,2,5 / 0,1,6,7 / 0,1,8 / 0,1,11; instr_count=4; pc_write_cond=1 only in state 8; pc_src=10 in state 11.
- opcode=111111 → 0,1,0; illegal_op=1 and stays set; instr_count unchanged; next addi retires and instr_count increments.
- reset=0 asserted while in MEMRD → next state FETCH; no reg_write pulse; instr_count=0.
- Run with CNT_W=4 and 16 R-type instructions → instr_count wraps to 0.
- With MIPS_MEM_WAIT_EN: mem_ready=0 for 2 cycles in FETCH → state stays 0 and pc_write=0 for those 2 cycles; pc_write=1 in the ready cycle; lw takes 7 cycles.
